// File: rtl/ram_port1_reader.sv
// rtl/ram_port1_reader.sv - burst reader for RAM port 1 feeding a credit-checked output FIFO
// Optional abort input is built only when RAM_RD_ABORT_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module ram_port1_reader #(
  parameter int AW    = `ADDR_WIDTH,
  parameter int DW    = `DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] burst_len,
`ifdef RAM_RD_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          csb1,
  output logic [AW-1:0] addr1,
  input  logic [DW-1:0] dout1,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          rd_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   next_addr, addr_hold, remaining;
  logic            inflight, issue, push, pop, kill;
  logic [PW:0]     count;
  logic [PW+1:0]   occupancy;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [DW-1:0]   fifo_mem [DEPTH];

`ifdef RAM_RD_ABORT_EN
  assign kill = abort && busy;
`else
  assign kill = 1'b0;
`endif

  // Credit covers both buffered words and the read whose data returns next edge.
  assign occupancy = (PW+2)'(count) + (PW+2)'(inflight);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start && burst_len != '0) state_nxt = READ;
      READ: begin
        issue = (remaining != '0) && (occupancy < DEPTH_W);
        if (issue && remaining == AW'(1)) state_nxt = DRAIN;
      end
      DRAIN: if (!inflight && count == '0) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) begin
      state_nxt = IDLE;
      issue     = 1'b0;
      done      = 1'b0;
    end
  end

  assign busy     = (state != IDLE);
  assign csb1     = ~issue;
  assign addr1    = issue ? next_addr : addr_hold;
  assign push     = inflight && !kill;
  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready && !kill;
  assign rd_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      next_addr <= '0;
      addr_hold <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (state == IDLE && start && burst_len != '0) begin
        next_addr <= base_addr;
        remaining <= burst_len;
      end
      if (issue) begin
        addr_hold <= next_addr;
        next_addr <= next_addr + AW'(1);
        remaining <= remaining - AW'(1);
      end
      if (kill) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (push) fifo_mem[wr_ptr] <= dout1;
  end

endmodule
